// File: rtl/fifo_uart_pkg.sv
// Shared types and frame-length helpers for the FIFO-fed UART transmitter.
// No logic of its own; everything here is elaboration-time.
// Imported by the transmitter top level and available to anything sizing around it.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Bit periods in one frame: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int data_width, input int parity_en,
                                    input int stop_bits);
    return 1 + data_width + ((parity_en != 0) ? 1 : 0) + stop_bits;
  endfunction

  // Clock cycles from the first start-bit cycle to the last stop-bit cycle.
  function automatic int frame_cycles(input int data_width, input int parity_en,
                                      input int stop_bits, input int clks_per_bit);
    return frame_bits(data_width, parity_en, stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: marks the last clk cycle of every CLKS_PER_BIT-cycle bit period.
// Latency: bit_tick is a decode of the registered counter, first tick CLKS_PER_BIT-1 cycles after clr.
// No backpressure; free-running, restarted by clr.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Count 0..CLKS_PER_BIT-1 and wrap; clr restarts the bit period at zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops FIFO words and serialises them as UART frames (start, data LSB first, parity, stop).
// Latency: strobe in T, LOAD in T+1, start bit on tx from T+2; frame_done in the last stop cycle.
// Backpressure: reads only in IDLE with enable high and FIFO non-empty; one strobe per word.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  // Bit counter is shared between data bits and stop bits (stop needs at most 0..1).
  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  state_t                state, state_d;
  logic [DATA_WIDTH-1:0] shift, shift_d;
  logic                  parity, parity_d;
  logic [BCW-1:0]        bit_cnt, bit_cnt_d;
  logic                  tx_d;
  logic                  bit_tick;
  logic                  baud_clr;

  // Bit periods are timed from the LOAD cycle so the start bit gets a full period.
  assign baud_clr = (state == LOAD);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (baud_clr),
    .bit_tick (bit_tick)
  );

  // Next-state, datapath updates and the line level to register for the next cycle.
  always_comb begin
    state_d    = state;
    shift_d    = shift;
    parity_d   = parity;
    bit_cnt_d  = bit_cnt;
    fifo_rd_en = 1'b0;
    frame_done = 1'b0;
    tx_d       = 1'b1;

    case (state)
      IDLE: begin
        if (enable && !fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        shift_d   = fifo_dout;
        parity_d  = ^fifo_dout;
        bit_cnt_d = '0;
        state_d   = START;
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = shift >> 1;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
            end else begin
              state_d = STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt + BCW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (bit_cnt == LAST_STOP) begin
            bit_cnt_d  = '0;
            frame_done = 1'b1;
            state_d    = IDLE;
          end else begin
            bit_cnt_d = bit_cnt + BCW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset wins over any strobe or completion pulse in the same cycle.
    if (rst) begin
      fifo_rd_en = 1'b0;
      frame_done = 1'b0;
    end

    // tx is registered, so it is derived from where the FSM is going next.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  // State, shift register, parity, bit counter and the registered serial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      parity  <= 1'b0;
      bit_cnt <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      shift   <= shift_d;
      parity  <= parity_d;
      bit_cnt <= bit_cnt_d;
      tx      <= tx_d;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: two transmitters (8N1 and 8E2, 4 clks/bit) fed by queue-style FIFO models.
// Expected line waveforms are built per word from the frame format; counts checked at the end.
// Inputs are driven just after the rising edge, outputs sampled on the falling edge.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en0, en1;
  logic       fake_ne;
  logic       sel;
  logic [7:0] mem0 [0:63];
  logic [7:0] mem1 [0:63];
  logic [5:0] wp0 = '0, rp0 = '0, wp1 = '0, rp1 = '0;
  logic [7:0] dout0, dout1;
  logic       empty0, empty1;
  logic       rd0, tx0, busy0, fd0;
  logic       rd1, tx1, busy1, fd1;

  int cyc = 0;
  int nstb0 = 0, nstb1 = 0, nfd0 = 0, nfd1 = 0, bad_rd = 0;
  int checks = 0, errors = 0;
  int frames0 = 0, frames1 = 0;

  assign empty0 = (wp0 == rp0) && !fake_ne;
  assign empty1 = (wp1 == rp1) && !fake_ne;

  wire tx_s   = sel ? tx1   : tx0;
  wire rd_s   = sel ? rd1   : rd0;
  wire busy_s = sel ? busy1 : busy0;
  wire fd_s   = sel ? fd1   : fd0;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .enable(en0), .fifo_empty(empty0), .fifo_dout(dout0),
    .fifo_rd_en(rd0), .tx(tx0), .busy(busy0), .frame_done(fd0));

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .fifo_empty(empty1), .fifo_dout(dout1),
    .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .frame_done(fd1));

  // FIFO read ports (registered data) and event counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd0 === 1'b1 && !empty0) begin dout0 <= mem0[rp0]; rp0 <= rp0 + 6'd1; end
    if (rd1 === 1'b1 && !empty1) begin dout1 <= mem1[rp1]; rp1 <= rp1 + 6'd1; end
    if (rd0 === 1'b1) nstb0 <= nstb0 + 1;
    if (rd1 === 1'b1) nstb1 <= nstb1 + 1;
    if ((rd0 === 1'b1 && empty0) || (rd1 === 1'b1 && empty1)) bad_rd <= bad_rd + 1;
    if (fd0 === 1'b1) nfd0 <= nfd0 + 1;
    if (fd1 === 1'b1) nfd1 <= nfd1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [7:0] v);
    mem0[wp0] = v;
    wp0 = wp0 + 6'd1;
  endtask

  task automatic push1(input logic [7:0] v);
    mem1[wp1] = v;
    wp1 = wp1 + 6'd1;
  endtask

  task automatic wait_strobe(output int t);
    t = -1;
    for (int n = 0; n < 200 && t < 0; n++) begin
      @(negedge clk);
      if (rd_s === 1'b1) t = cyc;
    end
    chk("strobe_seen", 32'(t >= 0), 32'd1);
  endtask

  // One whole frame for the selected DUT, from its read strobe to its last stop cycle.
  task automatic run_frame(input bit s, input logic [7:0] w, input int drop_at, output int tstb);
    logic [15:0] eb;
    int f, txe, fde, bze, rde;
    eb = '1;
    eb[0] = 1'b0;
    for (int i = 0; i < 8; i++) eb[1+i] = w[i];
    if (s) eb[9] = ^w;
    f = (s ? 12 : 10) * CPB;
    wait_strobe(tstb);
    if (tstb < 0) return;
    chk("idle_tx_high", 32'(tx_s), 32'd1);
    chk("idle_not_busy", 32'(busy_s), 32'd0);
    @(negedge clk);
    chk("load_busy", 32'(busy_s), 32'd1);
    chk("load_tx_high", 32'(tx_s), 32'd1);
    chk("load_no_rd", 32'(rd_s), 32'd0);
    txe = 0; fde = 0; bze = 0; rde = 0;
    for (int c = 0; c < f; c++) begin
      @(negedge clk);
      if (c == drop_at) begin
        if (s) en1 = 1'b0; else en0 = 1'b0;
      end
      if (tx_s !== eb[c/CPB]) txe++;
      if (fd_s !== (c == f - 1)) fde++;
      if (busy_s !== 1'b1) bze++;
      if (rd_s !== 1'b0) rde++;
    end
    chk("frame_tx_wave", 32'(txe), 32'd0);
    chk("frame_done_timing", 32'(fde), 32'd0);
    chk("frame_busy", 32'(bze), 32'd0);
    chk("frame_single_rd", 32'(rde), 32'd0);
    if (s) frames1++; else frames0++;
  endtask

  initial begin
    int t1, t2, te, n0, nf, k;
    logic [7:0] w [0:3];
    rst = 1'b1; en0 = 1'b0; en1 = 1'b0; fake_ne = 1'b0; sel = 1'b0;

    // Reset held with random enables and a random empty flag.
    for (int i = 0; i < 3; i++) begin
      go();
      en0 = 1'($urandom); en1 = 1'($urandom); fake_ne = 1'($urandom);
      @(negedge clk);
      chk("rst_tx0", 32'(tx0), 32'd1);     chk("rst_busy0", 32'(busy0), 32'd0);
      chk("rst_fd0", 32'(fd0), 32'd0);     chk("rst_rd0", 32'(rd0), 32'd0);
      chk("rst_tx1", 32'(tx1), 32'd1);     chk("rst_busy1", 32'(busy1), 32'd0);
      chk("rst_fd1", 32'(fd1), 32'd0);     chk("rst_rd1", 32'(rd1), 32'd0);
    end
    go();
    rst = 1'b0; fake_ne = 1'b0; en0 = 1'b1; en1 = 1'b0;

    // Single word 0xA5.
    n0 = nstb0;
    push0(8'hA5);
    run_frame(0, 8'hA5, -1, t1);
    @(negedge clk);
    chk("single_one_strobe", 32'(nstb0 - n0), 32'd1);
    chk("single_busy_drop", 32'(busy0), 32'd0);

    // Back-to-back 0x00 then 0xFF.
    go();
    n0 = nstb0;
    push0(8'h00); push0(8'hFF);
    run_frame(0, 8'h00, -1, t1);
    run_frame(0, 8'hFF, -1, t2);
    chk("b2b_gap", 32'(t2 - t1), 32'd42);
    repeat (10) @(negedge clk);
    chk("b2b_strobes", 32'(nstb0 - n0), 32'd2);
    chk("b2b_fifo_empty", 32'(empty0), 32'd1);
    chk("b2b_idle", 32'(busy0), 32'd0);

    // Random words back-to-back.
    go();
    for (int i = 0; i < 4; i++) begin w[i] = 8'($urandom); push0(w[i]); end
    run_frame(0, w[0], -1, t1);
    for (int i = 1; i < 4; i++) begin
      run_frame(0, w[i], -1, t2);
      chk("rand_gap", 32'(t2 - t1), 32'd42);
      t1 = t2;
    end

    // Even parity, two stop bits: 0x07 then random words.
    go();
    sel = 1'b1; en1 = 1'b1;
    push1(8'h07);
    w[0] = 8'($urandom); w[1] = 8'($urandom);
    push1(w[0]); push1(w[1]);
    run_frame(1, 8'h07, -1, t1);
    run_frame(1, w[0], -1, t2);
    chk("par_gap", 32'(t2 - t1), 32'd50);
    run_frame(1, w[1], -1, t2);
    @(negedge clk);
    chk("par_busy_drop", 32'(busy1), 32'd0);

    // Enable dropped mid-frame: frame completes, no fetch until enable returns.
    go();
    sel = 1'b0; en0 = 1'b1;
    for (int i = 0; i < 3; i++) begin w[i] = 8'($urandom); push0(w[i]); end
    run_frame(0, w[0], 12, t1);
    n0 = nstb0;
    k = int'($urandom_range(3, 12));
    for (int i = 0; i < k; i++) @(negedge clk);
    chk("drop_no_strobe", 32'(nstb0 - n0), 32'd0);
    chk("drop_idle", 32'(busy0), 32'd0);
    go();
    en0 = 1'b1;
    te = cyc;
    run_frame(0, w[1], -1, t2);
    chk("drop_refetch", 32'(t2 >= te && t2 - te <= 1), 32'd1);
    run_frame(0, w[2], -1, t2);

    // Reset during data bit 3; next queued word then goes out whole.
    go();
    w[0] = 8'($urandom); w[1] = 8'($urandom);
    push0(w[0]); push0(w[1]);
    wait_strobe(t1);
    repeat (18) @(negedge clk);
    chk("mid_bit3", 32'(tx0), 32'(w[0][3]));
    go();
    rst = 1'b1;
    nf = nfd0;
    @(negedge clk);
    go();
    @(negedge clk);
    chk("mid_rst_tx", 32'(tx0), 32'd1);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    chk("mid_rst_fd", 32'(fd0), 32'd0);
    chk("mid_rst_rd", 32'(rd0), 32'd0);
    go();
    rst = 1'b0;
    chk("mid_no_fd", 32'(nfd0 - nf), 32'd0);
    run_frame(0, w[1], -1, t2);
    repeat (3) @(negedge clk);

    chk("no_rd_when_empty", 32'(bad_rd), 32'd0);
    chk("fd_count0", 32'(nfd0), 32'(frames0));
    chk("fd_count1", 32'(nfd1), 32'(frames1));
    chk("strobe_count0", 32'(nstb0), 32'(frames0 + 1));
    chk("strobe_count1", 32'(nstb1), 32'(frames1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
